// File: rtl/execute_cycle.sv
// Purpose : RV32I execute stage. It applies operand forwarding, runs the ALU, resolves
//           branches and registers the results into EX/MEM. After a taken branch it kills
//           the younger instructions that are already in flight.
// Latency : 1 cycle from the EX inputs to the *M outputs. PCSrcE and PCTargetE are
//           combinational in the same cycle.
// Backpressure : none. The stage advances on every clock, and killed slots leave as bubbles.
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   RegWriteE..BranchE       ID/EX control bits
//   ALUControlE              ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   RD1_E, RD2_E, Imm_Ext_E  operands and immediate
//   RD_E, PCE, PCPlus4E      destination register and PCs
//   ForwardA_E, ForwardB_E   forwarding selects (01 = ResultW, 10 = ALUResultM)
//   ResultW                  writeback forward source
//   PCSrcE, PCTargetE        branch redirect toward fetch
//   *M                       EX/MEM pipeline register outputs
//   SquashE                  instruction currently in EX is being killed
module execute_cycle #(
  parameter int XLEN         = 32,
  parameter int SQUASH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [4:0]      RD_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic            SquashE
);

  localparam int CW = (SQUASH_DEPTH > 0) ? $clog2(SQUASH_DEPTH + 1) : 1;

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_res;
  logic            alu_lt, zero;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            regwrite_q, memwrite_q, resultsrc_q;
  logic            regwrite_d, memwrite_d;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_q, wdata_q, pcplus4_q;

  // Forwarding muxes. The 10 source is this stage's own registered result.
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = RD2_E;
    case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b  = ALUSrcE ? Imm_Ext_E : fwd_b;
  assign alu_lt = $signed(src_a) < $signed(src_b);

  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      3'b000:  alu_res = src_a + src_b;
      3'b001:  alu_res = src_a - src_b;
      3'b010:  alu_res = src_a & src_b;
      3'b011:  alu_res = src_a | src_b;
      3'b101:  alu_res = {{(XLEN-1){1'b0}}, alu_lt};
      default: alu_res = '0;
    endcase
  end

  assign zero      = (alu_res == '0);
  assign PCTargetE = PCE + Imm_Ext_E;

  // A branch that is itself on the wrong path must never redirect, so it is gated
  // by the squash state.
  assign SquashE = (cnt_q != '0);
  assign PCSrcE  = BranchE & zero & ~SquashE;

  always_comb begin
    cnt_d = cnt_q;
    if (PCSrcE)
      cnt_d = CW'(SQUASH_DEPTH);
    else if (SquashE)
      cnt_d = cnt_q - CW'(1);
  end

  // Killed slots keep their data fields. Only the architectural side effects are dropped.
  assign regwrite_d = RegWriteE & ~SquashE;
  assign memwrite_d = MemWriteE & ~SquashE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      rd_q        <= '0;
      alu_q       <= '0;
      wdata_q     <= '0;
      pcplus4_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      resultsrc_q <= ResultSrcE;
      rd_q        <= RD_E;
      alu_q       <= alu_res;
      wdata_q     <= fwd_b;
      pcplus4_q   <= PCPlus4E;
    end
  end

  assign RegWriteM  = regwrite_q;
  assign MemWriteM  = memwrite_q;
  assign ResultSrcM = resultsrc_q;
  assign RD_M       = rd_q;
  assign ALUResultM = alu_q;
  assign WriteDataM = wdata_q;
  assign PCPlus4M   = pcplus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: a scoreboard of expected EX/MEM contents, plus inline checks of
// the combinational branch outputs.
module tb_execute_cycle;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } m_t;

  logic        clk, rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE, RegWriteM, MemWriteM, ResultSrcM, SquashE;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;

  m_t obs;
  m_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0]  rd_seq = 5'd1;
  logic [31:0] pc_seq = 32'h0;

  execute_cycle #(.XLEN(32), .SQUASH_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .SquashE(SquashE)
  );

  assign obs = {RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies one instruction at the falling edge. Any pending reset is released together
  // with it.
  task automatic drive(input logic rw, input logic mw, input logic br, input logic asrc,
                       input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [1:0] fa, input logic [1:0] fb);
    @(negedge clk);
    rst = 1'b1;
    RegWriteE = rw; MemWriteE = mw; BranchE = br; ALUSrcE = asrc; ALUControlE = op;
    RD1_E = a; RD2_E = b; Imm_Ext_E = imm; ForwardA_E = fa; ForwardB_E = fb;
    RD_E = rd_seq; ResultSrcE = rd_seq[0]; PCE = pc_seq; PCPlus4E = pc_seq + 32'd4;
    rd_seq = rd_seq + 5'd1;
    pc_seq = pc_seq + 32'd4;
  endtask

  // Pushes the expected EX/MEM contents for the instruction currently being driven.
  task automatic expect_m(input logic rw, input logic mw, input logic [31:0] alu, input logic [31:0] wd);
    sb.push_back(m_t'({rw, mw, ResultSrcE, RD_E, alu, wd, PCPlus4E}));
  endtask

  task automatic test_reset;
    rst = 1'b0;
    RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 1'b1; BranchE = 1'b0; ALUSrcE = 1'b0;
    ALUControlE = 3'b000; RD1_E = 32'hA; RD2_E = 32'h3; Imm_Ext_E = 32'h0; RD_E = 5'd7;
    PCE = 32'h40; PCPlus4E = 32'h44; ForwardA_E = 2'b00; ForwardB_E = 2'b00; ResultW = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== '0) $display("FAIL reset_m got %h exp 0", obs); else n_pass++;
    n_checks++;
    if (SquashE !== 1'b0) $display("FAIL reset_squash got %b exp 0", SquashE); else n_pass++;
  endtask

  task automatic test_alu;
    logic [2:0]  ops [11];
    logic [31:0] as [11];
    logic [31:0] bs [11];
    logic [31:0] ex [11];
    m_t e;
    ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b100, 3'b111, 3'b101, 3'b001, 3'b000};
    as  = '{32'hA, 32'hA, 32'hA, 32'hA, 32'hA, 32'hA, 32'hA, 32'hA, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
    bs  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFF, 32'hFFFFFFFF, 32'hA, 32'h1, 32'h1};
    ex  = '{32'h9, 32'hB, 32'hA, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFF, 32'h0};
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, ops[i], as[i], bs[i], 32'h0, 2'b00, 2'b00);
      expect_m(1'b1, 1'b0, ex[i], bs[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL alu[%0d] op=%b got %h exp %h", i, ops[i], obs, e); else n_pass++;
    end
  endtask

  task automatic test_forward;
    logic [1:0]  fas [6];
    logic [1:0]  fbs [6];
    logic        srcs [6];
    logic [31:0] exa [6];
    logic [31:0] exw [6];
    m_t e;
    fas  = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
    fbs  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b11};
    srcs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exa  = '{32'h56, 32'h78, 32'h2, 32'h2, 32'h56, 32'h4};
    exw  = '{32'h3, 32'h3, 32'h3, 32'h77, 32'h55, 32'h3};
    ResultW = 32'h55;
    for (int i = 0; i < 6; i++) begin
      // The prior add leaves 0x77 in ALUResultM as the 10 forwarding source.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h70, 32'h0, 32'h7, 2'b00, 2'b00);
      expect_m(1'b1, 1'b0, 32'h77, 32'h0);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL fwd_prime[%0d] got %h exp %h", i, obs, e); else n_pass++;
      drive(1'b1, 1'b0, 1'b0, srcs[i], 3'b000, 32'h1, 32'h3, 32'h1, fas[i], fbs[i]);
      expect_m(1'b1, 1'b0, exa[i], exw[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL fwd[%0d] fa=%b fb=%b got %h exp %h", i, fas[i], fbs[i], obs, e); else n_pass++;
    end
  endtask

  task automatic test_branch;
    m_t e;
    pc_seq = 32'h100;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 32'h5, 32'h5, 32'h20, 2'b00, 2'b00);
    #1;
    n_checks++;
    if (PCSrcE !== 1'b1) $display("FAIL br_pcsrc got %b exp 1", PCSrcE); else n_pass++;
    n_checks++;
    if (PCTargetE !== 32'h120) $display("FAIL br_target got %h exp 00000120", PCTargetE); else n_pass++;
    n_checks++;
    if (SquashE !== 1'b0) $display("FAIL br_squash0 got %b exp 0", SquashE); else n_pass++;
    expect_m(1'b0, 1'b0, 32'h0, 32'h5);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) $display("FAIL br_commit got %h exp %h", obs, e); else n_pass++;

    // First wrong-path slot: an ordinary store-with-writeback.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h1, 32'h2, 32'h0, 2'b00, 2'b00);
    #1;
    n_checks++;
    if (SquashE !== 1'b1) $display("FAIL sq1_flag got %b exp 1", SquashE); else n_pass++;
    expect_m(1'b0, 1'b0, 32'h3, 32'h2);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) $display("FAIL sq1_bubble got %h exp %h", obs, e); else n_pass++;

    // Second wrong-path slot: a taken-condition beq that must not redirect.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 32'h7, 32'h7, 32'h40, 2'b00, 2'b00);
    #1;
    n_checks++;
    if (SquashE !== 1'b1) $display("FAIL sq2_flag got %b exp 1", SquashE); else n_pass++;
    n_checks++;
    if (PCSrcE !== 1'b0) $display("FAIL sq2_pcsrc got %b exp 0", PCSrcE); else n_pass++;
    n_checks++;
    if (PCTargetE !== 32'h148) $display("FAIL sq2_target got %h exp 00000148", PCTargetE); else n_pass++;
    expect_m(1'b0, 1'b0, 32'h0, 32'h7);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) $display("FAIL sq2_bubble got %h exp %h", obs, e); else n_pass++;

    // The third instruction after the branch commits.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h1, 32'h2, 32'h0, 2'b00, 2'b00);
    #1;
    n_checks++;
    if (SquashE !== 1'b0) $display("FAIL sq3_flag got %b exp 0", SquashE); else n_pass++;
    expect_m(1'b1, 1'b1, 32'h3, 32'h2);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) $display("FAIL sq3_commit got %h exp %h", obs, e); else n_pass++;
  endtask

  task automatic test_not_taken;
    m_t e;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 32'h5, 32'h6, 32'h20, 2'b00, 2'b00);
    #1;
    n_checks++;
    if (PCSrcE !== 1'b0) $display("FAIL nt_pcsrc got %b exp 0", PCSrcE); else n_pass++;
    expect_m(1'b0, 1'b0, 32'hFFFFFFFF, 32'h6);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) $display("FAIL nt_commit got %h exp %h", obs, e); else n_pass++;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 32'h3, 32'h4, 32'h0, 2'b00, 2'b00);
    #1;
    n_checks++;
    if (SquashE !== 1'b0) $display("FAIL nt_squash got %b exp 0", SquashE); else n_pass++;
    expect_m(1'b1, 1'b0, 32'h7, 32'h4);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) $display("FAIL nt_next got %h exp %h", obs, e); else n_pass++;
  endtask

  task automatic test_reset_mid_squash;
    m_t e;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 32'h9, 32'h9, 32'h8, 2'b00, 2'b00);
    expect_m(1'b0, 1'b0, 32'h0, 32'h9);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) $display("FAIL rms_branch got %h exp %h", obs, e); else n_pass++;
    // The squash counter now holds its maximum; reset must clear it without a clock edge.
    @(negedge clk);
    rst = 1'b0;
    RegWriteE = 1'b0; MemWriteE = 1'b0; BranchE = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0) $display("FAIL rms_m got %h exp 0", obs); else n_pass++;
    n_checks++;
    if (SquashE !== 1'b0) $display("FAIL rms_squash got %b exp 0", SquashE); else n_pass++;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h4, 32'h5, 32'h0, 2'b00, 2'b00);
    #1;
    n_checks++;
    if (SquashE !== 1'b0) $display("FAIL rms_after_flag got %b exp 0", SquashE); else n_pass++;
    expect_m(1'b1, 1'b1, 32'h9, 32'h5);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) $display("FAIL rms_after got %h exp %h", obs, e); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_forward;
    test_branch;
    test_not_taken;
    test_reset_mid_squash;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
